// File: rtl/boolean_bist.sv
// On-chip truth-table exerciser for a 3-input/1-output combinational block.
// Walks {a,b,c} through 000..111, samples f after a settle period, and reports mismatches.
module boolean_bist #(
  parameter logic [7:0]  EXPECTED = 8'b0000_0100,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [7:0] observed
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [7:0] hc_q, hc_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic       ffv_q, ffv_d;
  logic [2:0] ffvec_q, ffvec_d;
  logic [7:0] observed_q, observed_d;

  logic [7:0] obs_upd;
  logic       mismatch;

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    hc_d         = hc_q;
    abc_d        = abc_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    ffv_d        = ffv_q;
    ffvec_d      = ffvec_q;
    observed_d   = observed_q;

    // Table as it will look once the current vector's sample lands; pass uses this
    // so the vector-7 sample taken on the final edge is included.
    obs_upd       = observed_q;
    obs_upd[v_q]  = f;
    mismatch      = (f != EXPECTED[v_q]);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          v_d          = 3'd0;
          hc_d         = 8'd0;
          abc_d        = 3'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_count_d = 4'd0;
          ffv_d        = 1'b0;
          ffvec_d      = 3'd0;
          observed_d   = 8'd0;
        end
      end
      RUN: begin
        if (hc_q != SETTLE_C) begin
          hc_d = hc_q + 8'd1;
        end else begin
          observed_d = obs_upd;
          if (mismatch) begin
            fail_count_d = fail_count_q + 4'd1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = v_q;
            end
          end
          if (v_q != 3'd7) begin
            v_d   = v_q + 3'd1;
            hc_d  = 8'd0;
            abc_d = v_q + 3'd1;
          end else begin
            state_d = DONE;
            v_d     = 3'd0;
            hc_d    = 8'd0;
            abc_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (obs_upd == EXPECTED);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      v_q          <= 3'd0;
      hc_q         <= 8'd0;
      abc_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 4'd0;
      ffv_q        <= 1'b0;
      ffvec_q      <= 3'd0;
      observed_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      hc_q         <= hc_d;
      abc_q        <= abc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      ffv_q        <= ffv_d;
      ffvec_q      <= ffvec_d;
      observed_q   <= observed_d;
    end
  end

  assign {a, b, c}        = abc_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_count_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign observed         = observed_q;

endmodule

// File: tb/tb_boolean_bist.sv
// Bench for boolean_bist: two instances (SETTLE=2 and SETTLE=0) driving a table-defined
// DUT model, with a per-instance scoreboard queue checked by an independent monitor.
module tb_boolean_bist;

  localparam logic [7:0] EXP_TT = 8'b0000_0100;

  typedef struct {
    logic [7:0] obs;
    logic [3:0] fc;
    logic       ffv;
    logic [2:0] ffvec;
    logic       pass;
    int         accept;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst;
  logic [1:0] st;
  logic [7:0] tt [2];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s inst%0d @cyc%0d actual=0x%0h required=0x%0h", name, inst, cyc, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int S      = (gi == 0) ? 2 : 0;
    localparam int RUNLEN = 8 * (S + 1);

    logic       a_o, b_o, c_o, f_i, busy_o, done_o, pass_o, ffv_o;
    logic [3:0] fc_o;
    logic [2:0] ffvec_o;
    logic [7:0] obs_o;
    exp_t       sb[$];
    logic       done_prev = 1'b0;
    int         k;

    assign f_i = tt[gi][{a_o, b_o, c_o}];

    boolean_bist #(.EXPECTED(EXP_TT), .SETTLE(S)) u_dut (
      .clk              (clk),
      .reset            (rst[gi]),
      .start            (st[gi]),
      .a                (a_o),
      .b                (b_o),
      .c                (c_o),
      .f                (f_i),
      .busy             (busy_o),
      .done             (done_o),
      .pass             (pass_o),
      .fail_count       (fc_o),
      .first_fail_valid (ffv_o),
      .first_fail_vec   (ffvec_o),
      .observed         (obs_o)
    );

    // Monitor: k counts edges since the run's start was accepted.
    always begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        k = cyc - sb[0].accept;
        if (k >= 0 && k < RUNLEN) begin
          chk("abc_vector", gi, 32'({a_o, b_o, c_o}), 32'(k / (S + 1)));
          chk("busy_in_run", gi, 32'(busy_o), 32'd1);
          chk("done_in_run", gi, 32'(done_o), 32'd0);
        end else if (k == RUNLEN) begin
          chk("done_rise", gi, 32'(done_o), 32'd1);
          chk("busy_at_done", gi, 32'(busy_o), 32'd0);
          chk("abc_at_done", gi, 32'({a_o, b_o, c_o}), 32'd0);
          chk("pass", gi, 32'(pass_o), 32'(sb[0].pass));
          chk("observed", gi, 32'(obs_o), 32'(sb[0].obs));
          chk("fail_count", gi, 32'(fc_o), 32'(sb[0].fc));
          chk("first_fail_valid", gi, 32'(ffv_o), 32'(sb[0].ffv));
          chk("first_fail_vec", gi, 32'(ffvec_o), 32'(sb[0].ffvec));
          $display("[TB] inst%0d run@%0d: observed=%02h fail_count=%0d first_fail=%0d/%0d pass=%0d",
                   gi, sb[0].accept, obs_o, fc_o, ffv_o, ffvec_o, pass_o);
          void'(sb.pop_front());
        end
      end else if (done_o && !done_prev) begin
        chk("unexpected_done", gi, 32'(done_o), 32'd0);
      end
      done_prev = done_o;
    end
  end

  // Reference: F is sampled once per vector, so the captured table is the DUT table itself.
  function automatic exp_t model(input logic [7:0] t);
    exp_t e;
    e.obs = t; e.fc = 4'd0; e.ffv = 1'b0; e.ffvec = 3'd0; e.accept = 0;
    for (int v = 0; v < 8; v++) begin
      if (t[v] != EXP_TT[v]) begin
        e.fc = e.fc + 4'd1;
        if (!e.ffv) begin
          e.ffv   = 1'b1;
          e.ffvec = 3'(v);
        end
      end
    end
    e.pass = (e.fc == 4'd0);
    return e;
  endfunction

  task automatic push(input int inst, input exp_t e);
    if (inst == 0) g_inst[0].sb.push_back(e);
    else           g_inst[1].sb.push_back(e);
  endtask

  function automatic int pending(input int inst);
    return (inst == 0) ? g_inst[0].sb.size() : g_inst[1].sb.size();
  endfunction

  task automatic flush(input int inst);
    if (inst == 0) g_inst[0].sb.delete();
    else           g_inst[1].sb.delete();
  endtask

  function automatic logic [31:0] outs(input int inst);
    if (inst == 0)
      return 32'({g_inst[0].a_o, g_inst[0].b_o, g_inst[0].c_o, g_inst[0].busy_o, g_inst[0].done_o,
                  g_inst[0].pass_o, g_inst[0].ffv_o, g_inst[0].fc_o, g_inst[0].ffvec_o, g_inst[0].obs_o});
    return 32'({g_inst[1].a_o, g_inst[1].b_o, g_inst[1].c_o, g_inst[1].busy_o, g_inst[1].done_o,
                g_inst[1].pass_o, g_inst[1].ffv_o, g_inst[1].fc_o, g_inst[1].ffvec_o, g_inst[1].obs_o});
  endfunction

  task automatic launch(input int inst, input logic [7:0] t);
    exp_t e;
    tt[inst] = t;
    e = model(t);
    e.accept = cyc + 1;
    push(inst, e);
    st[inst] = 1'b1;
    @(negedge clk);
    st[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n = 0;
    while (pending(inst) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (pending(inst) != 0) begin
      chk("run_timeout", inst, 32'(pending(inst)), 32'd0);
      flush(inst);
    end
  endtask

  task automatic run(input int inst, input logic [7:0] t);
    launch(inst, t);
    wait_idle(inst);
  endtask

  initial begin
    exp_t e;
    rst = 2'b11; st = 2'b00; tt[0] = 8'h00; tt[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", 0, outs(0), 32'd0);
    chk("reset_outs", 1, outs(1), 32'd0);
    rst = 2'b00;
    @(negedge clk);

    // SETTLE=2: correct DUT, stuck-at-1, single wrong entry at 110
    run(0, 8'h04);
    run(0, 8'hFF);
    run(0, 8'h44);

    // Reset for two cycles while vector 3 is being held
    launch(0, 8'hFF);
    repeat (9) @(negedge clk);
    rst[0] = 1'b1;
    flush(0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    chk("midrun_reset_outs", 0, outs(0), 32'd0);
    run(0, 8'h04);

    // SETTLE=0: basic run, then start pulsed mid-run must be ignored
    run(1, 8'h04);
    launch(1, 8'h44);
    repeat (3) @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    wait_idle(1);

    // Start held high: done for one cycle, results cleared on the re-launch edge
    tt[1] = 8'hFF;
    e = model(8'hFF);
    e.accept = cyc + 1;
    push(1, e);
    e.accept = cyc + 1 + 9;
    push(1, e);
    st[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk("relaunch_clear", 1, outs(1), 32'h0004_0000);
    st[1] = 1'b0;
    wait_idle(1);

    // Reset and start on the same edge: reset wins
    rst[1] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0; st[1] = 1'b0;
    chk("reset_vs_start", 1, outs(1), 32'd0);
    @(negedge clk);
    chk("idle_after_reset_start", 1, outs(1), 32'd0);

    // Random truth tables on both instances
    for (int i = 0; i < 6; i++) begin
      run(0, 8'($urandom_range(0, 255)));
      run(1, (i == 2) ? EXP_TT : 8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
